// File: rtl/matmul_serial_core.sv
// N x N matrix multiplier C = A x B: elements stream in, one MAC per cycle, results stream out.
// A, B and C live in register banks; all ports are registered.
module matmul_serial_core #(
  parameter int unsigned N      = 3,
  parameter int unsigned W      = 8,
  parameter bit          SIGNED = 1'b0,
  localparam int unsigned ACC_W = 2 * W + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NN   = N * N;
  localparam int unsigned NN_W = $clog2(NN);
  localparam int unsigned LD_W = $clog2(2 * NN);
  localparam int unsigned I_W  = $clog2(N);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUTPUT, S_DONE} state_e;

  state_e state_q, state_d;

  logic [LD_W-1:0]  ld_idx_q, ld_idx_d;
  logic [I_W-1:0]   ci_q, ci_d, cj_q, cj_d, ck_q, ck_d;
  logic [NN_W-1:0]  out_idx_q, out_idx_d;
  logic [W-1:0]     a_q [NN];
  logic [W-1:0]     a_d [NN];
  logic [W-1:0]     b_q [NN];
  logic [W-1:0]     b_d [NN];
  logic [ACC_W-1:0] c_q [NN];
  logic [ACC_W-1:0] c_d [NN];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_c, out_fire_c, ld_last_c, mac_last_c, out_last_c;
  logic [NN_W-1:0]  a_addr_c, b_addr_c, c_addr_c;
  logic [ACC_W-1:0] prod_c;

  // Operand extension to the accumulator width; low ACC_W bits of the product are exact either way.
  function automatic logic [ACC_W-1:0] ext(input logic [W-1:0] x);
    if (SIGNED) return {{(ACC_W - W){x[W-1]}}, x};
    else        return {{(ACC_W - W){1'b0}}, x};
  endfunction

  assign accept_c   = in_valid & in_ready_q;
  assign out_fire_c = out_valid_q & out_ready;
  assign ld_last_c  = (ld_idx_q == LD_W'(2 * NN - 1));
  assign mac_last_c = (ci_q == I_W'(N - 1)) && (cj_q == I_W'(N - 1)) && (ck_q == I_W'(N - 1));
  assign out_last_c = (out_idx_q == NN_W'(NN - 1));
  assign a_addr_c   = NN_W'(ci_q) * NN_W'(N) + NN_W'(ck_q);
  assign b_addr_c   = NN_W'(ck_q) * NN_W'(N) + NN_W'(cj_q);
  assign c_addr_c   = NN_W'(ci_q) * NN_W'(N) + NN_W'(cj_q);
  assign prod_c     = ext(a_q[a_addr_c]) * ext(b_q[b_addr_c]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start) state_d = S_LOAD;
        S_LOAD:    if (accept_c && ld_last_c) state_d = S_COMPUTE;
        S_COMPUTE: if (mac_last_c) state_d = S_OUTPUT;
        S_OUTPUT:  if (out_fire_c && out_last_c) state_d = S_DONE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_idx_d  = ld_idx_q;
    ci_d      = ci_q;
    cj_d      = cj_q;
    ck_d      = ck_q;
    out_idx_d = out_idx_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    acc_d     = acc_q;
    if (clear) begin
      ld_idx_d  = '0;
      ci_d      = '0;
      cj_d      = '0;
      ck_d      = '0;
      out_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: ld_idx_d = '0;
        S_LOAD: begin
          if (accept_c) begin
            if (ld_idx_q < LD_W'(NN)) a_d[NN_W'(ld_idx_q)] = in_data;
            else                      b_d[NN_W'(ld_idx_q - LD_W'(NN))] = in_data;
            ld_idx_d = ld_last_c ? '0 : ld_idx_q + LD_W'(1);
          end
        end
        S_COMPUTE: begin
          acc_d = (ck_q == '0) ? prod_c : acc_q + prod_c;
          if (ck_q == I_W'(N - 1)) begin
            c_d[c_addr_c] = acc_d;
            ck_d = '0;
            if (cj_q == I_W'(N - 1)) begin
              cj_d = '0;
              ci_d = (ci_q == I_W'(N - 1)) ? '0 : ci_q + I_W'(1);
            end else begin
              cj_d = cj_q + I_W'(1);
            end
          end else begin
            ck_d = ck_q + I_W'(1);
          end
        end
        S_OUTPUT: if (out_fire_c) out_idx_d = out_last_c ? '0 : out_idx_q + NN_W'(1);
        default: ;
      endcase
    end
    // Port flops follow the next state so they line up with the state they describe.
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_OUTPUT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    out_data_d  = (state_d == S_OUTPUT) ? c_q[out_idx_d] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_idx_q    <= '0;
      ci_q        <= '0;
      cj_q        <= '0;
      ck_q        <= '0;
      out_idx_q   <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < int'(NN); i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      ld_idx_q    <= ld_idx_d;
      ci_q        <= ci_d;
      cj_q        <= cj_d;
      ck_q        <= ck_d;
      out_idx_q   <= out_idx_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matmul_serial_core.sv
// Directed bench for matmul_serial_core: unsigned/signed 3x3 at W=8 and unsigned 4x4 at W=4.
module tb_matmul_serial_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear, start, in_valid, out_ready;
  logic [7:0] din;
  int         sel;
  int         checks = 0, errors = 0;
  int         cyc = 0, t_start = 0, done_cnt = 0;
  logic [7:0]  vals [32];
  logic [31:0] expv [16];

  logic st0, st1, st2, iv0, iv1, iv2;
  logic rdy0, rdy1, rdy2, ov0, ov1, ov2, busy0, busy1, busy2, done0, done1, done2;
  logic [17:0] od0, od1;
  logic [9:0]  od2;
  logic        rdy, ov, bsy, dn;
  logic [17:0] od;

  always_comb begin
    st0 = start && (sel == 0);
    st1 = start && (sel == 1);
    st2 = start && (sel == 2);
    iv0 = in_valid && (sel == 0);
    iv1 = in_valid && (sel == 1);
    iv2 = in_valid && (sel == 2);
    case (sel)
      0:       begin rdy = rdy0; ov = ov0; od = od0;       bsy = busy0; dn = done0; end
      1:       begin rdy = rdy1; ov = ov1; od = od1;       bsy = busy1; dn = done1; end
      default: begin rdy = rdy2; ov = ov2; od = 18'(od2);  bsy = busy2; dn = done2; end
    endcase
  end

  matmul_serial_core #(.N(3), .W(8), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(st0), .clear(clear), .in_valid(iv0), .in_data(din),
    .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
    .busy(busy0), .done(done0));

  matmul_serial_core #(.N(3), .W(8), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(st1), .clear(clear), .in_valid(iv1), .in_data(din),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
    .busy(busy1), .done(done1));

  matmul_serial_core #(.N(4), .W(4), .SIGNED(1'b0)) u_dut_4 (
    .clk(clk), .rst_n(rst_n), .start(st2), .clear(clear), .in_valid(iv2), .in_data(din[3:0]),
    .in_ready(rdy2), .out_valid(ov2), .out_data(od2), .out_ready(out_ready),
    .busy(busy2), .done(done2));

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done0 || done1 || done2) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_job();
    @(negedge clk);
    start   = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic load_beats(input int nn, input bit gaps);
    int t;
    for (int k = 0; k < 2 * nn; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      din      = vals[k];
      t = 0;
      while (!rdy && t < 100) begin @(negedge clk); t++; end
      if (!rdy) begin
        check("in_ready_timeout", 32'(rdy), 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int nn, input int ncol, input int stall, input bit chk_lat);
    int t;
    for (int i = 0; i < ncol; i++) begin
      out_ready = (stall == 0);
      t = 0;
      while (!ov && t < 300) begin @(negedge clk); t++; end
      if (!ov) begin
        check("out_valid_timeout", 32'(ov), 1);
        out_ready = 1'b0;
        return;
      end
      if (i == 0 && chk_lat) check("latency", 32'(cyc - t_start), 46);
      for (int s = 0; s < stall; s++) begin
        check("stall_data", 32'(od), expv[i]);
        @(negedge clk);
      end
      out_ready = 1'b1;
      check("c_data", 32'(od), expv[i]);
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (ncol == nn) begin
      check("done_pulse", 32'(dn), 1);
      check("done_busy", 32'(bsy), 1);
      check("done_ov", 32'(ov), 0);
      @(negedge clk);
      check("done_low", 32'(dn), 0);
      check("idle_busy", 32'(bsy), 0);
    end
  endtask

  // A = scale*I, B = b0 + bstep*k, expected C[k] = scale*(b0 + bstep*k)
  task automatic setup_ident(input int scale, input int b0, input int bstep);
    for (int k = 0; k < 9; k++) begin
      vals[k]     = (k / 3 == k % 3) ? 8'(scale) : 8'd0;
      vals[9 + k] = 8'(b0 + bstep * k);
      expv[k]     = 32'(scale * (b0 + bstep * k));
    end
  endtask

  task automatic setup_rand4();
    int s;
    for (int k = 0; k < 32; k++) vals[k] = 8'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(vals[i * 4 + k]) * int'(vals[16 + k * 4 + j]);
        expv[i * 4 + j] = 32'(s);
      end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din = '0; sel = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(rdy0), 0);
    check("rst_out_valid", 32'(ov0), 0);
    check("rst_out_data", 32'(od0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_busy_s", 32'(busy1), 0);
    check("rst_busy_4", 32'(busy2), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // identity times 1..9
    sel = 0;
    setup_ident(1, 1, 1);
    dc = done_cnt;
    start_job();
    load_beats(9, 1'b0);
    collect(9, 9, 0, 1'b1);
    check("done_once", 32'(done_cnt - dc), 1);

    // unsigned maximum operands
    for (int k = 0; k < 18; k++) vals[k] = 8'hFF;
    for (int k = 0; k < 9; k++) expv[k] = 32'h2FA03;
    start_job();
    load_beats(9, 1'b0);
    collect(9, 9, 0, 1'b1);

    // signed: all -128, then identity times -1..-9
    sel = 1;
    for (int k = 0; k < 18; k++) vals[k] = 8'h80;
    for (int k = 0; k < 9; k++) expv[k] = 32'd49152;
    start_job();
    load_beats(9, 1'b0);
    collect(9, 9, 0, 1'b1);
    setup_ident(1, -1, -1);
    for (int k = 0; k < 9; k++) expv[k] = 32'h40000 - 32'(k + 1);
    start_job();
    load_beats(9, 1'b0);
    collect(9, 9, 0, 1'b1);

    // backpressure on both ports
    sel = 0;
    setup_ident(1, 1, 1);
    start_job();
    load_beats(9, 1'b1);
    collect(9, 9, 5, 1'b0);

    // start and stray in_valid during COMPUTE are ignored
    start_job();
    load_beats(9, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; in_valid = 1'b1; din = 8'hFF;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    check("compute_busy", 32'(bsy), 1);
    check("compute_in_ready", 32'(rdy), 0);
    collect(9, 9, 0, 1'b1);

    // asynchronous reset mid-COMPUTE
    start_job();
    load_beats(9, 1'b0);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy0), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy0), 0);
    check("arst_in_ready", 32'(rdy0), 0);
    check("arst_out_valid", 32'(ov0), 0);
    check("arst_out_data", 32'(od0), 0);
    check("arst_done", 32'(done0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    setup_ident(2, 1, 1);
    start_job();
    load_beats(9, 1'b0);
    collect(9, 9, 0, 1'b1);

    // clear after four results, then clear+start together in IDLE
    setup_ident(1, 1, 1);
    dc = done_cnt;
    start_job();
    load_beats(9, 1'b0);
    collect(9, 4, 0, 1'b0);
    do_clear();
    check("clr_busy", 32'(bsy), 0);
    check("clr_out_valid", 32'(ov), 0);
    check("clr_no_done", 32'(done_cnt - dc), 0);
    @(negedge clk);
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check("clr_start_idle", 32'(bsy), 0);
    setup_ident(1, 9, -1);
    start_job();
    load_beats(9, 1'b0);
    collect(9, 9, 0, 1'b1);

    // N=4, W=4 against the reference model
    sel = 2;
    setup_rand4();
    dc = done_cnt;
    start_job();
    load_beats(16, 1'b1);
    collect(16, 4, 2, 1'b0);
    do_clear();
    check("clr4_busy", 32'(bsy), 0);
    check("clr4_no_done", 32'(done_cnt - dc), 0);
    setup_rand4();
    start_job();
    load_beats(16, 1'b0);
    collect(16, 16, 0, 1'b0);
    setup_rand4();
    start_job();
    load_beats(16, 1'b1);
    collect(16, 16, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
